// File: rtl/mc_sched_pkg.sv
// Shared types and constants for the memory-controller request scheduler.
package mc_sched_pkg;

  localparam int DEPTH   = 16;
  localparam int SLOT_W  = $clog2(DEPTH);
  localparam int OCC_W   = SLOT_W + 1;
  localparam int ADDR_W  = 32;
  localparam int AGE_W   = 6;
  localparam int SCORE_W = 8;

  localparam logic [AGE_W-1:0]   AGE_MAX    = '1;
  localparam logic [SCORE_W-1:0] W_CLASS3   = SCORE_W'(128);
  localparam logic [SCORE_W-1:0] W_CLASS2   = SCORE_W'(8);
  localparam logic [SCORE_W-1:0] W_CLASS1   = SCORE_W'(2);
  localparam logic [SCORE_W-1:0] W_CLASS0   = SCORE_W'(0);
  localparam logic [SCORE_W-1:0] READ_BONUS = SCORE_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        req_class;
    logic              is_write;
  } sched_req_t;

  function automatic logic [SCORE_W-1:0] class_weight(input logic [1:0] cls);
    case (cls)
      2'd3:    return W_CLASS3;
      2'd2:    return W_CLASS2;
      2'd1:    return W_CLASS1;
      default: return W_CLASS0;
    endcase
  endfunction

endpackage

// File: rtl/mc_request_scheduler_if.sv
// Front-end enqueue and DRAM-command issue handshakes plus queue status.
interface mc_request_scheduler_if;
  import mc_sched_pkg::*;

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [1:0]        enq_class;
  logic              enq_is_write;
  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_is_write;
  logic [SLOT_W-1:0] iss_slot;
  logic [OCC_W-1:0]  occupancy;
  logic              empty;

  modport master (
    output enq_valid, enq_addr, enq_class, enq_is_write, iss_ready,
    input  enq_ready, iss_valid, iss_addr, iss_is_write, iss_slot, occupancy, empty
  );

  modport slave (
    input  enq_valid, enq_addr, enq_class, enq_is_write, iss_ready,
    output enq_ready, iss_valid, iss_addr, iss_is_write, iss_slot, occupancy, empty
  );

endinterface

// File: rtl/mc_sched_argmax.sv
// Highest-score valid slot; strict greater-than keeps ties on the lowest index.
module mc_sched_argmax
  import mc_sched_pkg::*;
(
  input  logic [DEPTH-1:0]   valid,
  input  logic [SCORE_W-1:0] score [DEPTH],
  output logic [SLOT_W-1:0]  win_slot,
  output logic               any_valid
);

  logic [SCORE_W-1:0] best;
  logic               found;

  always_comb begin
    best     = '0;
    found    = 1'b0;
    win_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (!found || score[i] > best)) begin
        best     = score[i];
        win_slot = SLOT_W'(i);
        found    = 1'b1;
      end
    end
    any_valid = found;
  end

endmodule

// File: rtl/mc_request_scheduler.sv
// 16-slot aging request queue feeding a single-entry issue register.
// state | meaning
// IDLE  | nothing to issue, waiting for a queued request
// PICK  | argmax entry moves from its slot into the issue register
// HOLD  | iss_valid high, issue register stable until iss_ready
module mc_request_scheduler
  import mc_sched_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mc_request_scheduler_if.slave bus
);

  sched_state_t       state, state_nxt;
  logic [DEPTH-1:0]   slot_valid;
  sched_req_t         slot_req   [DEPTH];
  logic [AGE_W-1:0]   slot_age   [DEPTH];
  logic [SCORE_W-1:0] slot_score [DEPTH];

  logic [OCC_W-1:0]  occ, occ_nxt;
  logic [SLOT_W-1:0] free_slot, win_slot;
  logic              free_found, any_valid, full, enq_fire, pick;
  logic [ADDR_W-1:0] iss_addr_q;
  logic              iss_wr_q;
  logic [SLOT_W-1:0] iss_slot_q;

  always_comb begin
    occ        = '0;
    free_slot  = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(slot_valid[i]);
      if (!slot_valid[i] && !free_found) begin
        free_slot  = SLOT_W'(i);
        free_found = 1'b1;
      end
      slot_score[i] = slot_valid[i]
                    ? class_weight(slot_req[i].req_class) + SCORE_W'(slot_age[i])
                      + (slot_req[i].is_write ? SCORE_W'(0) : READ_BONUS)
                    : '0;
    end
  end

  mc_sched_argmax u_argmax (
    .valid     (slot_valid),
    .score     (slot_score),
    .win_slot  (win_slot),
    .any_valid (any_valid)
  );

  assign full     = &slot_valid;
  assign enq_fire = bus.enq_valid && !full;
  assign pick     = (state == PICK) && any_valid;
  assign occ_nxt  = occ + OCC_W'(enq_fire) - OCC_W'(pick);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (occ_nxt != '0) state_nxt = PICK;
      PICK:    state_nxt = any_valid ? HOLD : IDLE;
      HOLD:    if (bus.iss_ready) state_nxt = (occ_nxt != '0) ? PICK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Enqueue targets a slot free at cycle start, so it can never collide with the pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_req[i] <= '0;
        slot_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_fire && free_slot == SLOT_W'(i)) begin
          slot_valid[i]         <= 1'b1;
          slot_req[i].addr      <= bus.enq_addr;
          slot_req[i].req_class <= bus.enq_class;
          slot_req[i].is_write  <= bus.enq_is_write;
          slot_age[i]           <= '0;
        end else if (pick && win_slot == SLOT_W'(i)) begin
          slot_valid[i] <= 1'b0;
        end else if (slot_valid[i] && slot_age[i] != AGE_MAX) begin
          slot_age[i] <= slot_age[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_addr_q <= '0;
      iss_wr_q   <= 1'b0;
      iss_slot_q <= '0;
    end else if (pick) begin
      iss_addr_q <= slot_req[win_slot].addr;
      iss_wr_q   <= slot_req[win_slot].is_write;
      iss_slot_q <= win_slot;
    end
  end

  assign bus.enq_ready    = !full;
  assign bus.iss_valid    = (state == HOLD);
  assign bus.iss_addr     = iss_addr_q;
  assign bus.iss_is_write = iss_wr_q;
  assign bus.iss_slot     = iss_slot_q;
  assign bus.occupancy    = occ;
  assign bus.empty        = (occ == '0);

endmodule

// File: tb/tb_mc_request_scheduler.sv
// Directed stimulus for mc_request_scheduler with a cycle-stamped queue model checked every cycle.
module tb_mc_request_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_request_scheduler_if bus_if ();

  mc_request_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: entries carry the cycle they were enqueued in; age is derived from that stamp.
  bit          m_valid [16];
  logic [31:0] m_addr  [16];
  logic [1:0]  m_cls   [16];
  bit          m_wr    [16];
  int          m_tenq  [16];
  int          m_cyc;
  bit          m_pick_now, m_iss_valid;
  logic [31:0] m_iss_addr;
  bit          m_iss_wr;
  int          m_iss_slot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int m_score(input int i);
    int age, w;
    age = m_cyc - m_tenq[i] - 1;
    if (age > 63) age = 63;
    case (m_cls[i])
      2'd3: w = 128;
      2'd2: w = 8;
      2'd1: w = 2;
      default: w = 0;
    endcase
    return w + age + (m_wr[i] ? 0 : 4);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_addr[i] = '0; m_cls[i] = '0; m_wr[i] = 0; m_tenq[i] = 0;
    end
    m_cyc = 0; m_pick_now = 0; m_iss_valid = 0;
    m_iss_addr = '0; m_iss_wr = 0; m_iss_slot = 0;
  endtask

  task automatic m_step();
    int cnt, new_cnt, best_i, best_s, s, fs;
    bit enq, hs;
    cnt    = m_cnt();
    enq    = bus_if.enq_valid && cnt < 16;
    hs     = m_iss_valid && bus_if.iss_ready;
    best_i = -1;
    best_s = -1;
    if (m_pick_now) begin
      for (int i = 0; i < 16; i++) begin
        if (m_valid[i]) begin
          s = m_score(i);
          if (s > best_s) begin best_s = s; best_i = i; end
        end
      end
    end
    fs = -1;
    if (enq) begin
      for (int i = 0; i < 16; i++) if (!m_valid[i] && fs < 0) fs = i;
    end
    new_cnt = cnt + int'(enq) - ((best_i >= 0) ? 1 : 0);
    m_pick_now  = (!m_iss_valid && !m_pick_now && new_cnt > 0) || (hs && new_cnt > 0);
    m_iss_valid = (best_i >= 0) || (m_iss_valid && !bus_if.iss_ready);
    if (best_i >= 0) begin
      m_iss_addr = m_addr[best_i];
      m_iss_wr   = m_wr[best_i];
      m_iss_slot = best_i;
      m_valid[best_i] = 0;
    end
    if (fs >= 0) begin
      m_valid[fs] = 1;
      m_addr[fs]  = bus_if.enq_addr;
      m_cls[fs]   = bus_if.enq_class;
      m_wr[fs]    = bus_if.enq_is_write;
      m_tenq[fs]  = m_cyc;
    end
    m_cyc++;
  endtask

  initial begin : compare
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      chk("enq_ready",    bus_if.enq_ready,    (m_cnt() < 16) ? 1 : 0);
      chk("occupancy",    bus_if.occupancy,    m_cnt());
      chk("empty",        bus_if.empty,        (m_cnt() == 0) ? 1 : 0);
      chk("iss_valid",    bus_if.iss_valid,    m_iss_valid);
      chk("iss_addr",     bus_if.iss_addr,     m_iss_addr);
      chk("iss_is_write", bus_if.iss_is_write, m_iss_wr);
      chk("iss_slot",     bus_if.iss_slot,     m_iss_slot);
      if (rst_n) m_step();
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic enq(input logic [31:0] a, input logic [1:0] c, input logic w);
    bus_if.enq_valid    = 1'b1;
    bus_if.enq_addr     = a;
    bus_if.enq_class    = c;
    bus_if.enq_is_write = w;
    @(posedge clk); #1;
    bus_if.enq_valid = 1'b0;
  endtask

  task automatic next_issue(output logic [31:0] a, output logic w, output logic [3:0] s);
    bit got = 0;
    a = '0; w = 1'b0; s = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus_if.iss_valid && bus_if.iss_ready) begin
        a = bus_if.iss_addr; w = bus_if.iss_is_write; s = bus_if.iss_slot; got = 1;
      end
      @(posedge clk); #1;
    end
    chk("issue_wait", got, 1);
  endtask

  task automatic drain();
    bit done = 0;
    bus_if.iss_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus_if.empty && !bus_if.iss_valid) done = 1;
      @(posedge clk); #1;
    end
    chk("drain_done", done, 1);
  endtask

  logic [31:0] a;
  logic        w;
  logic [3:0]  s;
  int          order [8];

  initial begin : stimulus
    rst_n = 1'b0;
    bus_if.enq_valid = 1'b0; bus_if.enq_addr = '0; bus_if.enq_class = '0;
    bus_if.enq_is_write = 1'b0; bus_if.iss_ready = 1'b0;
    @(negedge clk);
    chk("rst_iss_valid", bus_if.iss_valid, 0);
    chk("rst_empty",     bus_if.empty, 1);
    chk("rst_enq_ready", bus_if.enq_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // single read: PICK one cycle after enqueue, iss_valid the cycle after that
    bus_if.iss_ready = 1'b1;
    enq(32'h100, 2'd0, 1'b0);
    @(negedge clk);
    chk("t1_c1_iss_valid", bus_if.iss_valid, 0);
    chk("t1_c1_occ",       bus_if.occupancy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_c2_iss_valid", bus_if.iss_valid, 1);
    chk("t1_c2_addr",      bus_if.iss_addr, 32'h100);
    chk("t1_c2_wr",        bus_if.iss_is_write, 0);
    chk("t1_c2_slot",      bus_if.iss_slot, 0);
    chk("t1_c2_occ",       bus_if.occupancy, 0);
    @(posedge clk); #1;
    idle(3);

    // class-3 write overtakes an aged class-0 read
    bus_if.iss_ready = 1'b0;
    enq(32'h200, 2'd0, 1'b0); idle(3);
    enq(32'h300, 2'd0, 1'b0); idle(20);
    enq(32'h400, 2'd3, 1'b1); idle(2);
    bus_if.iss_ready = 1'b1;
    next_issue(a, w, s); chk("t2_dummy_addr", a, 32'h200);
    next_issue(a, w, s); chk("t2_c3_addr", a, 32'h400); chk("t2_c3_wr", w, 1); chk("t2_c3_slot", s, 1);
    next_issue(a, w, s); chk("t2_c0_addr", a, 32'h300); chk("t2_c0_slot", s, 0);
    idle(3);

    // read bonus beats one extra cycle of age
    bus_if.iss_ready = 1'b0;
    enq(32'h500, 2'd0, 1'b0); idle(3);
    enq(32'h600, 2'd1, 1'b1);
    enq(32'h700, 2'd1, 1'b0); idle(5);
    bus_if.iss_ready = 1'b1;
    next_issue(a, w, s); chk("t3_dummy_addr", a, 32'h500);
    next_issue(a, w, s); chk("t3_read_addr", a, 32'h700); chk("t3_read_wr", w, 0); chk("t3_read_slot", s, 1);
    next_issue(a, w, s); chk("t3_write_addr", a, 32'h600); chk("t3_write_wr", w, 1);
    idle(3);

    // saturated ages: reads in 3 and 7 tie, writes in the rest tie
    bus_if.iss_ready = 1'b0;
    enq(32'h800, 2'd0, 1'b0); idle(3);
    for (int k = 0; k < 8; k++) enq(32'h1000 + k, 2'd0, (k == 3 || k == 7) ? 1'b0 : 1'b1);
    idle(80);
    order = '{3, 7, 0, 1, 2, 4, 5, 6};
    bus_if.iss_ready = 1'b1;
    next_issue(a, w, s); chk("t4_dummy_addr", a, 32'h800);
    for (int k = 0; k < 8; k++) begin
      next_issue(a, w, s);
      chk("t4_order_slot", s, order[k]);
      chk("t4_order_addr", a, 32'h1000 + order[k]);
    end
    idle(3);

    // full queue: 16 queued plus one in the issue register
    bus_if.iss_ready = 1'b0;
    for (int k = 0; k < 17; k++) enq(32'h2000 + k, 2'(k % 4), 1'(k % 2));
    bus_if.enq_valid = 1'b1; bus_if.enq_addr = 32'h2fff;
    bus_if.enq_class = 2'd2; bus_if.enq_is_write = 1'b0;
    idle(3);
    @(negedge clk);
    chk("t5_full_occ",   bus_if.occupancy, 16);
    chk("t5_full_ready", bus_if.enq_ready, 0);
    chk("t5_full_iss",   bus_if.iss_valid, 1);
    @(posedge clk); #1;
    bus_if.iss_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.iss_ready = 1'b0;
    @(negedge clk);
    chk("t5_pick_ready", bus_if.enq_ready, 0);
    chk("t5_pick_occ",   bus_if.occupancy, 16);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_freed_occ",   bus_if.occupancy, 15);
    chk("t5_freed_ready", bus_if.enq_ready, 1);
    @(posedge clk); #1;
    bus_if.enq_valid = 1'b0;
    @(negedge clk);
    chk("t5_refill_occ",   bus_if.occupancy, 16);
    chk("t5_refill_ready", bus_if.enq_ready, 0);
    @(posedge clk); #1;
    drain();
    idle(2);

    // async reset while holding an issue with 5 queued
    bus_if.iss_ready = 1'b0;
    for (int k = 0; k < 6; k++) enq(32'h3000 + k, 2'd1, 1'b0);
    idle(2);
    @(negedge clk);
    chk("t6_pre_iss", bus_if.iss_valid, 1);
    chk("t6_pre_occ", bus_if.occupancy, 5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_iss",   bus_if.iss_valid, 0);
    chk("t6_rst_occ",   bus_if.occupancy, 0);
    chk("t6_rst_empty", bus_if.empty, 1);
    chk("t6_rst_ready", bus_if.enq_ready, 1);
    chk("t6_rst_addr",  bus_if.iss_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_if.iss_ready = 1'b1;
    enq(32'habc, 2'd2, 1'b0);
    @(negedge clk);
    chk("t6_c1_iss", bus_if.iss_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_c2_iss",  bus_if.iss_valid, 1);
    chk("t6_c2_addr", bus_if.iss_addr, 32'habc);
    chk("t6_c2_slot", bus_if.iss_slot, 0);
    @(posedge clk); #1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
